// File: rtl/mdu_iter.sv
// Iterative MIPS-style multiply/divide unit. It runs one bit per cycle and owns the
// architectural HI/LO registers. It also raises a stall while MFHI/MFLO waits on a result.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             hilo_rd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned DW = 2 * WIDTH;

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state, stateNxt;
  logic [CW-1:0]    count;
  logic             isDiv, negRes, negRem, divZero;
  logic [WIDTH:0]   accHi;
  logic [WIDTH-1:0] accLo, operand, origA;

  logic             loadOp, moveHi, moveLo, lastIter;
  logic [WIDTH-1:0] magA, magB;
  logic [WIDTH:0]   mulSum, divShift, divDiff;
  logic             divTake;
  logic [WIDTH:0]   accHiNxt;
  logic [WIDTH-1:0] accLoNxt;
  logic [DW-1:0]    prod, prodFix;
  logic [WIDTH-1:0] resHi, resLo;

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= stateNxt;
  end

  // Next-state logic
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (start) stateNxt = CALC;
      CALC:    if (count == CW'(WIDTH - 1)) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Control decode: moves and launches are only honoured while idle
  always_comb begin
    busy     = 1'b0;
    loadOp   = 1'b0;
    moveHi   = 1'b0;
    moveLo   = 1'b0;
    lastIter = 1'b0;
    case (state)
      IDLE: begin
        loadOp = start;
        moveHi = mthi;
        moveLo = mtlo;
      end
      CALC: begin
        busy     = 1'b1;
        lastIter = (count == CW'(WIDTH - 1));
      end
      default: ;
    endcase
  end

  assign stall = hilo_rd & busy;

  // Operand magnitudes (signed ops use op[0]=0) and one shift-add / restoring step
  always_comb begin
    magA     = (!op[0] && busA[WIDTH-1]) ? WIDTH'(-busA) : busA;
    magB     = (!op[0] && busB[WIDTH-1]) ? WIDTH'(-busB) : busB;
    mulSum   = {1'b0, accHi[WIDTH-1:0]} + (accLo[0] ? {1'b0, operand} : (WIDTH + 1)'(0));
    divShift = {accHi[WIDTH-1:0], accLo[WIDTH-1]};
    divDiff  = divShift - {1'b0, operand};
    divTake  = (divShift >= {1'b0, operand});
    if (isDiv) begin
      accHiNxt = divTake ? divDiff : divShift;
      accLoNxt = {accLo[WIDTH-2:0], divTake};
    end else begin
      accHiNxt = {1'b0, mulSum[WIDTH:1]};
      accLoNxt = {mulSum[0], accLo[WIDTH-1:1]};
    end
    prod    = {accHiNxt[WIDTH-1:0], accLoNxt};
    prodFix = negRes ? DW'(-prod) : prod;
    if (!isDiv) begin
      resHi = prodFix[DW-1:WIDTH];
      resLo = prodFix[WIDTH-1:0];
    end else if (divZero) begin
      resHi = origA;
      resLo = '1;
    end else begin
      resHi = negRem ? WIDTH'(-accHiNxt[WIDTH-1:0]) : accHiNxt[WIDTH-1:0];
      resLo = negRes ? WIDTH'(-accLoNxt) : accLoNxt;
    end
  end

  // Datapath, HI/LO and done pulse
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count   <= '0;
      isDiv   <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      accHi   <= '0;
      accLo   <= '0;
      operand <= '0;
      origA   <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= lastIter;
      if (loadOp) begin
        isDiv   <= op[1];
        negRes  <= !op[0] && (busA[WIDTH-1] ^ busB[WIDTH-1]);
        negRem  <= !op[0] && busA[WIDTH-1];
        divZero <= op[1] && (busB == '0);
        origA   <= busA;
        count   <= '0;
        accHi   <= '0;
        operand <= op[1] ? magB : magA;
        accLo   <= op[1] ? magA : magB;
      end else if (busy) begin
        accHi <= accHiNxt;
        accLo <= accLoNxt;
        count <= count + CW'(1);
      end
      if (lastIter) begin
        hi <= resHi;
        lo <= resLo;
      end else begin
        if (moveHi) hi <= busA;
        if (moveLo) lo <= busA;
      end
    end
  end

endmodule
